// File: rtl/aib_link_bringup_ctrl.sv
// AIB leader bring-up sequencer: config table writes, adapter reset/MAC ready release,
// link wait with timeout and bounded retries.
module aib_link_bringup_ctrl #(
  parameter int unsigned ACTIVE_CHNLS = 1,
  parameter int unsigned NBR_CHNLS    = 24,
  parameter int unsigned NUM_CFG      = 4,
  parameter logic [NUM_CFG*53-1:0] CFG_TABLE = '0,
  parameter int unsigned RST_DLY      = 32,
  parameter int unsigned MAC_DLY      = 16,
  parameter int unsigned LINK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                 i_cfg_avmm_clk,
  input  logic                 i_cfg_avmm_rst_n,
  input  logic                 start,
  output logic [16:0]          o_cfg_avmm_addr,
  output logic [3:0]           o_cfg_avmm_byte_en,
  output logic [31:0]          o_cfg_avmm_wdata,
  output logic                 o_cfg_avmm_write,
  input  logic                 i_cfg_avmm_waitreq,
  output logic [NBR_CHNLS-1:0] ns_adapter_rstn,
  output logic [NBR_CHNLS-1:0] ns_mac_rdy,
  input  logic [NBR_CHNLS-1:0] fs_mac_rdy,
  input  logic [NBR_CHNLS-1:0] m_rx_align_done,
  output logic                 link_up,
  output logic                 link_fail,
  output logic [3:0]           retry_cnt,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCfgWr    = 3'd1,
    StRstWait  = 3'd2,
    StMacWait  = 3'd3,
    StWaitLink = 3'd4,
    StLinkUp   = 3'd5,
    StFail     = 3'd6
  } state_e;

  localparam logic [NBR_CHNLS-1:0] ActMask  = {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);
  localparam logic [3:0]           LastIdx  = 4'(NUM_CFG - 1);
  localparam logic [19:0]          RstLast  = 20'(RST_DLY - 1);
  localparam logic [19:0]          MacLast  = 20'(MAC_DLY - 1);
  localparam logic [19:0]          LinkLast = 20'(LINK_TIMEOUT - 1);
  localparam logic [3:0]           MaxRetry = 4'(MAX_RETRY);

  function automatic logic [52:0] cfg_entry(input logic [3:0] i);
    return CFG_TABLE[53*int'(i) +: 53];
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d, retry_q, retry_d;
  logic [19:0]           cnt_q, cnt_d;
  logic                  boot_q, start_q;
  logic                  wr_q, wr_d, link_up_q, link_up_d, link_fail_q, link_fail_d;
  logic [16:0]           addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [NBR_CHNLS-1:0]  rstn_q, rstn_d, mac_q, mac_d;
  logic [NBR_CHNLS-1:0]  fs_s1_q, fs_s2_q, al_s1_q, al_s2_q;
  logic                  ok, start_edge, lost, restart;

  assign ok         = &((fs_s2_q & al_s2_q) | ~ActMask);
  assign start_edge = start & ~start_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rstn_d      = rstn_q;
    mac_d       = mac_q;
    link_up_d   = link_up_q;
    link_fail_d = link_fail_q;
    lost        = 1'b0;
    restart     = 1'b0;
    case (state_q)
      StIdle:    restart = boot_q | start_edge;
      StCfgWr: begin
        if (!i_cfg_avmm_waitreq) begin
          if (idx_q == LastIdx) begin
            wr_d    = 1'b0;
            cnt_d   = '0;
            state_d = StRstWait;
          end else begin
            idx_d                    = idx_q + 4'd1;
            {be_d, addr_d, wdata_d}  = cfg_entry(idx_q + 4'd1);
          end
        end
      end
      StRstWait: begin
        if (cnt_q == RstLast) begin
          rstn_d  = ActMask;
          cnt_d   = '0;
          state_d = StMacWait;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StMacWait: begin
        if (cnt_q == MacLast) begin
          mac_d   = ActMask;
          cnt_d   = '0;
          state_d = StWaitLink;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StWaitLink: begin
        // ok takes priority over a coincident timeout
        if (ok) begin
          link_up_d = 1'b1;
          state_d   = StLinkUp;
        end else if (cnt_q == LinkLast) begin
          lost = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StLinkUp: begin
        if (start_edge) restart = 1'b1;
        else if (!ok)   lost    = 1'b1;
      end
      StFail:    restart = start_edge;
      default:   state_d = StIdle;
    endcase

    if (lost) begin
      link_up_d = 1'b0;
      rstn_d    = '0;
      mac_d     = '0;
      cnt_d     = '0;
      if (retry_q < MaxRetry) begin
        retry_d = retry_q + 4'd1;
        state_d = StRstWait;
      end else begin
        link_fail_d = 1'b1;
        state_d     = StFail;
      end
    end

    if (restart) begin
      state_d                 = StCfgWr;
      idx_d                   = '0;
      wr_d                    = 1'b1;
      {be_d, addr_d, wdata_d} = cfg_entry(4'd0);
      retry_d                 = '0;
      rstn_d                  = '0;
      mac_d                   = '0;
      link_up_d               = 1'b0;
      link_fail_d             = 1'b0;
    end
  end

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      boot_q      <= 1'b1;
      start_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rstn_q      <= '0;
      mac_q       <= '0;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
      fs_s1_q     <= '0;
      fs_s2_q     <= '0;
      al_s1_q     <= '0;
      al_s2_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      boot_q      <= 1'b0;
      start_q     <= start;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rstn_q      <= rstn_d;
      mac_q       <= mac_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
      fs_s1_q     <= fs_mac_rdy;
      fs_s2_q     <= fs_s1_q;
      al_s1_q     <= m_rx_align_done;
      al_s2_q     <= al_s1_q;
    end
  end

  assign o_cfg_avmm_addr    = addr_q;
  assign o_cfg_avmm_byte_en = be_q;
  assign o_cfg_avmm_wdata   = wdata_q;
  assign o_cfg_avmm_write   = wr_q;
  assign ns_adapter_rstn    = rstn_q;
  assign ns_mac_rdy         = mac_q;
  assign link_up            = link_up_q;
  assign link_fail          = link_fail_q;
  assign retry_cnt          = retry_q;
  assign state              = state_q;

endmodule

// File: doc/aib_link_bringup_ctrl.md
# aib_link_bringup_ctrl

Bring-up sequencer for the AIB leader bridge. Out of reset, or on `start`, it:
- writes a parameter-defined table of AIB configuration registers over the config Avalon-MM port;
- releases the per-channel adapter resets and asserts near-side MAC ready;
- waits, with a timeout, for far-side MAC ready and RX alignment on every active channel;
- retries a bounded number of times, then reports link-up or failure to the AXI master bridge's system logic.

## Interface
- `ACTIVE_CHNLS`, default 1: channels brought up, always the lowest-indexed channels (1..NBR_CHNLS).
- `NBR_CHNLS`, default 24: width of the per-channel vectors.
- `NUM_CFG`, default 4: number of config writes (1..16).
- `CFG_TABLE`, default all zeros, `NUM_CFG*53` bits: packed entries; entry i sits at [53*i +: 53] = {byte_en[3:0], addr[16:0], data[31:0]}.
- `RST_DLY`, default 32: cycles between the last config write and adapter reset release.
- `MAC_DLY`, default 16: cycles between adapter reset release and `ns_mac_rdy` assertion.
- `LINK_TIMEOUT`, default 65535: cycles allowed in WAIT_LINK (1..2^20-1).
- `MAX_RETRY`, default 3: retries after the first attempt before FAIL.
- `i_cfg_avmm_clk`, input, 1: single clock for the whole block.
- `i_cfg_avmm_rst_n`, input, 1: asynchronous assert, active-low reset.
- `start`, input, 1: rising-edge-detected request to (re)run the sequence from IDLE, LINK_UP or FAIL.
- `o_cfg_avmm_addr`, output, 17: config address.
- `o_cfg_avmm_byte_en`, output, 4: config byte enables.
- `o_cfg_avmm_wdata`, output, 32: config write data.
- `o_cfg_avmm_write`, output, 1: config write request.
- `i_cfg_avmm_waitreq`, input, 1: config slave stall.
- `ns_adapter_rstn`, output, NBR_CHNLS: per-channel adapter reset, active-low.
- `ns_mac_rdy`, output, NBR_CHNLS: per-channel near-side MAC ready.
- `fs_mac_rdy`, input, NBR_CHNLS: far-side MAC ready; asynchronous to this block.
- `m_rx_align_done`, input, NBR_CHNLS: RX alignment done; asynchronous to this block.
- `link_up`, output, 1: every active channel is ready and aligned.
- `link_fail`, output, 1: retries exhausted.
- `retry_cnt`, output, 4: attempts made after the first.
- `state`, output, 3: encoded FSM state, for debug.

## Operation
- `fs_mac_rdy` and `m_rx_align_done` pass through 2-flop synchronizers before any use.
- Define `ok` = AND over the active channels of (sync fs_mac_rdy & sync m_rx_align_done).
- FSM states and encodings: IDLE=0, CFG_WR=1, RST_WAIT=2, MAC_WAIT=3, WAIT_LINK=4, LINK_UP=5, FAIL=6.
- The first cycle after reset deassertion goes IDLE→CFG_WR automatically. After that, IDLE is left only on a `start` edge.
- **CFG_WR**
  - Presents entry `idx`, starting at 0, with `o_cfg_avmm_write`=1.
  - An entry is accepted in a cycle where write=1 and waitreq=0.
  - On acceptance, `idx` increments. When `idx`=NUM_CFG-1 is accepted, go to RST_WAIT.
- **RST_WAIT**
  - Counts RST_DLY cycles with adapter resets held at 0.
  - On exit, `ns_adapter_rstn` is set to 1 on the active channels and goes to MAC_WAIT.
- **MAC_WAIT**
  - Counts MAC_DLY cycles.
  - On exit, `ns_mac_rdy` is set to 1 on the active channels and goes to WAIT_LINK with the timer cleared.
- **WAIT_LINK**
  - If `ok`: go to LINK_UP.
  - Else, if the timer reaches LINK_TIMEOUT-1 with retry_cnt<MAX_RETRY: increment retry_cnt, drop all `ns_mac_rdy` and `ns_adapter_rstn`, go to RST_WAIT. The config table is not rewritten.
  - Else, if the timer reaches LINK_TIMEOUT-1 with retries exhausted: go to FAIL.
  - If `ok` and timeout occur in the same cycle, `ok` wins.
- **LINK_UP**
  - `link_up`=1.
  - If `ok` drops for one cycle, treat it as a timeout event: same retry/fail rule, with `link_up` cleared in that cycle's transition.
- **FAIL**
  - `link_fail`=1.
  - `ns_adapter_rstn`=0 and `ns_mac_rdy`=0.
- **`start` edge**
  - Honored only in IDLE, LINK_UP or FAIL; ignored in all other states.
  - Clears retry_cnt, drops resets and mac_rdy, goes to CFG_WR with idx=0.
- Inactive channels (index ≥ ACTIVE_CHNLS) always drive 0 on `ns_adapter_rstn` and `ns_mac_rdy`.

## Timing
- Reset values:
  - all Avalon outputs 0;
  - `ns_adapter_rstn`=0, `ns_mac_rdy`=0;
  - `link_up`=0, `link_fail`=0, `retry_cnt`=0;
  - `state`=IDLE.
- All outputs are registered.
- Avalon writes follow these rules:
  - addr, byte_en, wdata and write are stable while waitreq=1.
  - Back-to-back writes need no bubble: entry i+1 is presented in the cycle after entry i is accepted.
  - write=0 in the cycle after the last acceptance.
- Cycle counts:
  - Adapter reset release occurs exactly RST_DLY cycles after the last accepted write.
  - `ns_mac_rdy` asserts MAC_DLY cycles after reset release.
- Link detection latency: `ok` inputs reach `link_up` in 3 cycles (2 sync + 1 state register).
- Reset assertion mid-write drops `o_cfg_avmm_write` asynchronously; no partial retry occurs.

## Test plan
- NUM_CFG=3, waitreq=0:
  - writes occur on 3 consecutive cycles with table addr/data;
  - rstn rises 32 cycles later, mac_rdy 16 after that;
  - fs/align driven high → link_up 3 cycles later.
- waitreq held high for 5 cycles on entry 1 → addr/data/write stable throughout; exactly 3 accepted writes.
- fs/align never asserted, LINK_TIMEOUT=100, MAX_RETRY=2:
  - rstn/mac_rdy pulse low twice, retry_cnt goes 1 then 2;
  - link_fail=1 after the third timeout.
- In LINK_UP, drop align for 1 cycle → link_up clears, retry_cnt increments, sequence restarts at RST_WAIT and recovers.
- ACTIVE_CHNLS=2 with NBR_CHNLS=24:
  - only bits [1:0] of rstn/mac_rdy assert;
  - channel 1 stuck unaligned blocks link_up.
- `start` pulse in FAIL → retry_cnt=0 and the config table is rewritten. Async reset asserted in WAIT_LINK → all outputs return to reset values immediately.
